dilithium_host_if: RTL

DILITHIUM_HOST_IF -- requirements
Module: dilithium_host_if

---
 rtl/dilithium_host_pkg.sv | 22 ++
 rtl/dilithium_byte_packer.sv | 91 +++++++++
 rtl/dilithium_host_if.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dilithium_host_pkg.sv
// dilithium_host_pkg
//   Shared types and constants for the Dilithium host byte-stream front end:
//   FSM state encoding, command mode codes and the payload byte-count width.
package dilithium_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_PACK,
        ST_FLUSH,
        ST_WAIT_DONE,
        ST_DROP
    } host_state_t;

    localparam logic [1:0] MODE_KEYGEN  = 2'd0;
    localparam logic [1:0] MODE_SIGN    = 2'd1;
    localparam logic [1:0] MODE_VERIFY  = 2'd2;
    localparam logic [1:0] MODE_ILLEGAL = 2'd3;

    localparam int BYTE_CNT_W = 16;

endpackage

// File: rtl/dilithium_byte_packer.sv
// dilithium_byte_packer
//   Packs accepted bytes little-endian into W-bit words (first byte in bits
//   [7:0]). Holds the accumulator, the byte index and the output register.
//   A completed word goes straight to the output register when it is free,
//   otherwise it waits in the accumulator and further bytes are refused.
// Ports
//   clk, rst       clock, asynchronous active-low reset
//   i_push         a byte is accepted this cycle
//   i_byte/i_last  byte value and end-of-frame marker (closes and zero-pads)
//   o_ready        packer can take a byte this cycle
//   o_acc_full     a completed word is parked in the accumulator
//   o_m_valid/i_m_ready/o_m_data  output word stream
module dilithium_byte_packer #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [7:0]   i_byte,
    input  logic         i_last,
    output logic         o_ready,
    output logic         o_acc_full,
    output logic         o_m_valid,
    input  logic         i_m_ready,
    output logic [W-1:0] o_m_data
);
    localparam int NB = W / 8;
    localparam int IW = $clog2(NB);

    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_out;
    logic [IW-1:0] r_idx;
    logic          r_full;
    logic          r_vld;

    logic          w_out_free;
    logic          w_close;
    logic [W-1:0]  w_word;

    // Output register can be loaded when empty or being drained this cycle.
    assign w_out_free = !r_vld || i_m_ready;
    assign w_close    = i_push && (i_last || (r_idx == IW'(NB - 1)));

    // The accumulator is zeroed after each word, so a short final word is
    // automatically zero-padded above the last byte.
    always_comb begin
        w_word = r_acc;
        w_word[8*r_idx +: 8] = i_byte;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc  <= '0;
            r_out  <= '0;
            r_idx  <= '0;
            r_full <= 1'b0;
            r_vld  <= 1'b0;
        end else begin
            if (r_vld && i_m_ready)
                r_vld <= 1'b0;
            // A parked word implies r_vld, so no byte can be pushed here.
            if (r_full && w_out_free) begin
                r_out  <= r_acc;
                r_vld  <= 1'b1;
                r_acc  <= '0;
                r_full <= 1'b0;
            end else if (i_push) begin
                if (w_close) begin
                    r_idx <= '0;
                    if (w_out_free) begin
                        r_out <= w_word;
                        r_vld <= 1'b1;
                        r_acc <= '0;
                    end else begin
                        r_acc  <= w_word;
                        r_full <= 1'b1;
                    end
                end else begin
                    r_acc <= w_word;
                    r_idx <= r_idx + IW'(1);
                end
            end
        end
    end

    assign o_ready    = !(r_full && r_vld);
    assign o_acc_full = r_full;
    assign o_m_valid  = r_vld;
    assign o_m_data   = r_out;

endmodule

// File: rtl/dilithium_host_if.sv
// dilithium_host_if
//   Host byte-stream front end for a Dilithium core. The first byte of a frame
//   is the command (bits[1:0] = mode); remaining bytes are packed into W-bit
//   words for the core. Illegal mode 3 sets a sticky err and drops the frame.
// Ports
//   clk, rst                          clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last     host byte stream
//   core_start/core_mode/core_done    core control
//   m_valid/m_ready/m_data            packed payload words
//   busy, err                         frame in progress, sticky illegal flag
//   byte_cnt                          payload bytes in current frame
//                                     (only with HOST_IF_BYTE_COUNT_EN)
module dilithium_host_if
    import dilithium_host_pkg::*;
#(
    parameter int W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [7:0]            s_data,
    input  logic                  s_last,
    output logic                  core_start,
    output logic [1:0]            core_mode,
    input  logic                  core_done,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [W-1:0]          m_data,
    output logic                  busy,
`ifdef HOST_IF_BYTE_COUNT_EN
    output logic [BYTE_CNT_W-1:0] byte_cnt,
`endif
    output logic                  err
);
    host_state_t r_state;
    logic        r_core_start;
    logic [1:0]  r_core_mode;
    logic        r_err;
    logic        r_empty;

    logic        w_accept;
    logic        w_push;
    logic        w_cmd_go;
    logic        w_pk_ready;
    logic        w_acc_full;

    assign w_accept = s_valid && s_ready;
    assign w_push   = w_accept && (r_state == ST_PACK);
    assign w_cmd_go = w_accept && (r_state == ST_IDLE) && (s_data[1:0] != MODE_ILLEGAL);

    always_comb begin
        s_ready = 1'b0;
        case (r_state)
            ST_IDLE, ST_DROP: s_ready = 1'b1;
            ST_PACK:          s_ready = w_pk_ready;
            default:          s_ready = 1'b0;
        endcase
    end

    dilithium_byte_packer #(.W(W)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_byte     (s_data),
        .i_last     (s_last),
        .o_ready    (w_pk_ready),
        .o_acc_full (w_acc_full),
        .o_m_valid  (m_valid),
        .i_m_ready  (m_ready),
        .o_m_data   (m_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_core_start <= 1'b0;
            r_core_mode  <= MODE_KEYGEN;
            r_err        <= 1'b0;
            r_empty      <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_go) begin
                        r_core_mode  <= s_data[1:0];
                        r_empty      <= s_last;
                        r_core_start <= 1'b1;   // high for the START cycle only
                        r_state      <= ST_START;
                    end else if (w_accept) begin
                        r_err <= 1'b1;
                        if (!s_last)
                            r_state <= ST_DROP;
                    end
                end
                ST_START:
                    r_state <= r_empty ? ST_WAIT_DONE : ST_PACK;
                ST_PACK:
                    if (w_push && s_last)
                        r_state <= ST_FLUSH;
                // The last word may still be parked behind an earlier one.
                ST_FLUSH:
                    if (m_valid && m_ready && !w_acc_full)
                        r_state <= ST_WAIT_DONE;
                ST_WAIT_DONE:
                    if (core_done)
                        r_state <= ST_IDLE;
                ST_DROP:
                    if (w_accept && s_last)
                        r_state <= ST_IDLE;
                default:
                    r_state <= ST_IDLE;
            endcase
        end
    end

    assign core_start = r_core_start;
    assign core_mode  = r_core_mode;
    assign err        = r_err;
    assign busy       = (r_state != ST_IDLE);

`ifdef HOST_IF_BYTE_COUNT_EN
    logic [BYTE_CNT_W-1:0] r_byte_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_byte_cnt <= '0;
        else if (w_cmd_go)
            r_byte_cnt <= '0;
        else if (w_push && (r_byte_cnt != '1))
            r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
    end

    assign byte_cnt = r_byte_cnt;
`endif

endmodule
